// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller and datapath ALU:
// FSM states, ALU operation codes, opcode/funct constants and mux encodings.
package mips_pkg;

  typedef enum logic [3:0] {
    S_RST,
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_R_EXEC,
    S_R_WB,
    S_I_EXEC,
    S_I_WB,
    S_BRANCH,
    S_JUMP
  } state_t;

  // Which source the ALU decoder uses to pick the operation code.
  typedef enum logic [1:0] {
    CLS_FIXED,
    CLS_R,
    CLS_I
  } alu_class_t;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SLL = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_AND = 3'd3;
  localparam logic [2:0] ALU_SUB = 3'd4;
  localparam logic [2:0] ALU_LUI = 3'd5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;

  localparam logic [1:0] SRCB_REG     = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  // True for the immediate-form ALU instructions that share I_EXEC/I_WB.
  function automatic logic is_itype(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_LUI);
  endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU decoder: picks the ALU operation from funct (R_EXEC) or
// opcode (I_EXEC), and flags whether the opcode/funct pair is supported.
module mips_alu_decoder
  import mips_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  alu_class_t  alu_class,
  output logic [2:0]  alu_control,
  output logic        imm_zero_ext,
  output logic        legal
);

  // Legality is independent of the requesting state so DECODE can use it.
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_LW, OP_SW, OP_BEQ, OP_J,
      OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: legal = 1'b1;
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLL: legal = 1'b1;
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

  // Operation select: funct for R-type execute, opcode for immediate execute.
  always_comb begin
    alu_control  = ALU_ADD;
    imm_zero_ext = 1'b0;
    case (alu_class)
      CLS_R: begin
        case (funct)
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLL:  alu_control = ALU_SLL;
          default: alu_control = ALU_ADD;
        endcase
      end
      CLS_I: begin
        case (opcode)
          OP_ANDI: begin
            alu_control  = ALU_AND;
            imm_zero_ext = 1'b1;
          end
          OP_ORI: begin
            alu_control  = ALU_OR;
            imm_zero_ext = 1'b1;
          end
          OP_LUI:  alu_control = ALU_LUI;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main controller: a Moore FSM that walks each instruction
// through fetch/decode/execute/memory/write-back and drives the datapath
// enables, mux selects and ALU operation code.
module mips_multicycle_control
  import mips_pkg::*;
#(
  parameter int WORD_LENGTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       imm_zero_ext,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       instr_done,
  output logic       illegal
);

  // The controller is width-agnostic; the parameter only documents the datapath.
  if (WORD_LENGTH != 32) begin : g_nonstandard_width
  end

  state_t     state;
  state_t     state_next;
  logic       reset_hold;
  alu_class_t alu_class;
  logic [2:0] dec_alu_control;
  logic       dec_imm_zero_ext;
  logic       dec_legal;

  mips_alu_decoder u_alu_decoder (
    .opcode       (opcode),
    .funct        (funct),
    .alu_class    (alu_class),
    .alu_control  (dec_alu_control),
    .imm_zero_ext (dec_imm_zero_ext),
    .legal        (dec_legal)
  );

  // Keeps the FSM in RST for one extra edge after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) reset_hold <= 1'b1;
    else       reset_hold <= 1'b0;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_RST;
    else       state <= state_next;
  end

  // Next-state and per-state outputs.
  always_comb begin
    state_next    = state;
    alu_class     = CLS_FIXED;
    alu_control   = ALU_ADD;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    imm_zero_ext  = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PCSRC_ALU;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    instr_done    = 1'b0;
    illegal       = 1'b0;

    case (state)
      S_RST: begin
        state_next = reset_hold ? S_RST : S_FETCH;
      end
      S_FETCH: begin
        mem_read   = 1'b1;
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        alu_src_b  = SRCB_FOUR;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        if (!dec_legal) begin
          illegal    = 1'b1;
          state_next = S_FETCH;
        end else begin
          case (opcode)
            OP_LW, OP_SW: state_next = S_MEM_ADDR;
            OP_RTYPE:     state_next = S_R_EXEC;
            OP_BEQ:       state_next = S_BRANCH;
            OP_J:         state_next = S_JUMP;
            default:      state_next = is_itype(opcode) ? S_I_EXEC : S_FETCH;
          endcase
        end
      end
      S_MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        state_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read   = 1'b1;
        i_or_d     = 1'b1;
        state_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_R_EXEC: begin
        alu_class   = CLS_R;
        alu_control = dec_alu_control;
        alu_src_a   = 1'b1;
        alu_src_b   = SRCB_REG;
        state_next  = S_R_WB;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_I_EXEC: begin
        alu_class    = CLS_I;
        alu_control  = dec_alu_control;
        imm_zero_ext = dec_imm_zero_ext;
        alu_src_a    = 1'b1;
        alu_src_b    = SRCB_IMM;
        state_next   = S_I_WB;
      end
      S_I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_REG;
        alu_control   = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        instr_done    = 1'b1;
        state_next    = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_RST;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control: directed instructions from
// the test plan, then randomized instruction streams compared cycle by cycle
// against a per-instruction expected-output table, plus a mid-lw reset.
module tb_mips_multicycle_control;

  typedef struct packed {
    logic [2:0] alu;
    logic       src_a;
    logic [1:0] src_b;
    logic       zext;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       rwr;
    logic       pcw;
    logic       pcwc;
    logic [1:0] pcsrc;
    logic       rdst;
    logic       m2r;
    logic       done;
    logic       ill;
  } outs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic [2:0] alu_control;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       imm_zero_ext, i_or_d, mem_read, mem_write, ir_write, reg_write;
  logic       pc_write, pc_write_cond;
  logic [1:0] pc_source;
  logic       reg_dst, mem_to_reg, instr_done, illegal;

  outs_t obs;
  outs_t expSeq [5];
  int    checks   = 0;
  int    failures = 0;

  mips_multicycle_control #(.WORD_LENGTH(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .funct         (funct),
    .alu_control   (alu_control),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .imm_zero_ext  (imm_zero_ext),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_source     (pc_source),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .instr_done    (instr_done),
    .illegal       (illegal)
  );

  always #5 clk = ~clk;

  assign obs = {alu_control, alu_src_a, alu_src_b, imm_zero_ext, i_or_d, mem_read,
                mem_write, ir_write, reg_write, pc_write, pc_write_cond, pc_source,
                reg_dst, mem_to_reg, instr_done, illegal};

  task automatic checkOutput(input string tag, input outs_t got, input outs_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: the list of cycles an instruction takes and what each shows.
  task automatic buildExpected(input logic [5:0] op, input logic [5:0] fn, output int n);
    outs_t fetchC, decodeC, c3, c4, c5;
    logic  rLegal;
    logic [2:0] rAlu;
    fetchC = '0; fetchC.src_b = 2'd1; fetchC.mrd = 1; fetchC.irw = 1; fetchC.pcw = 1;
    decodeC = '0; decodeC.src_b = 2'd3;
    c3 = '0; c4 = '0; c5 = '0;
    rLegal = 1'b1;
    rAlu = 3'd0;
    case (fn)
      6'h20: rAlu = 3'd0;
      6'h22: rAlu = 3'd4;
      6'h24: rAlu = 3'd3;
      6'h25: rAlu = 3'd2;
      6'h00: rAlu = 3'd1;
      default: rLegal = 1'b0;
    endcase
    n = 2;
    case (op)
      6'h23: begin
        c3.src_a = 1; c3.src_b = 2'd2;
        c4.mrd = 1; c4.iord = 1;
        c5.rwr = 1; c5.m2r = 1; c5.done = 1;
        n = 5;
      end
      6'h2B: begin
        c3.src_a = 1; c3.src_b = 2'd2;
        c4.mwr = 1; c4.iord = 1; c4.done = 1;
        n = 4;
      end
      6'h00: begin
        if (rLegal) begin
          c3.src_a = 1; c3.alu = rAlu;
          c4.rwr = 1; c4.rdst = 1; c4.done = 1;
          n = 4;
        end else decodeC.ill = 1;
      end
      6'h08, 6'h0C, 6'h0D, 6'h0F: begin
        c3.src_a = 1; c3.src_b = 2'd2;
        c3.alu = (op == 6'h08) ? 3'd0 : (op == 6'h0C) ? 3'd3 : (op == 6'h0D) ? 3'd2 : 3'd5;
        c3.zext = (op == 6'h0C) || (op == 6'h0D);
        c4.rwr = 1; c4.done = 1;
        n = 4;
      end
      6'h04: begin
        c3.src_a = 1; c3.alu = 3'd4; c3.pcwc = 1; c3.pcsrc = 2'd1; c3.done = 1;
        n = 3;
      end
      6'h02: begin
        c3.pcw = 1; c3.pcsrc = 2'd2; c3.done = 1;
        n = 3;
      end
      default: decodeC.ill = 1;
    endcase
    expSeq[0] = fetchC; expSeq[1] = decodeC; expSeq[2] = c3; expSeq[3] = c4; expSeq[4] = c5;
  endtask

  // Runs one instruction starting 1ns after the edge that entered FETCH.
  task automatic applyStimulus(input string name, input logic [5:0] op, input logic [5:0] fn);
    int n;
    buildExpected(op, fn, n);
    opcode = op;
    funct  = fn;
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s op=%h fn=%h cyc%0d", name, op, fn, i + 1), obs, expSeq[i]);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyReset(input int cycles);
    reset = 1'b1;
    #1;
    checkOutput("reset_async", obs, '0);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("reset_hold%0d", i), obs, '0);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset_release_edge1", obs, '0);
    @(posedge clk);
    #1;
  endtask

  logic [5:0] legalOps [9] = '{6'h23, 6'h2B, 6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h04, 6'h02};
  logic [5:0] legalFns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h00};

  initial begin
    int sel;
    logic [5:0] op, fn;
    outs_t memRd;
    reset  = 1'b1;
    opcode = 6'h00;
    funct  = 6'h00;
    #2;
    applyReset(3);

    applyStimulus("sub",  6'h00, 6'h22);
    applyStimulus("lw",   6'h23, 6'h11);
    applyStimulus("sw",   6'h2B, 6'h00);
    applyStimulus("ori",  6'h0D, 6'h05);
    applyStimulus("lui",  6'h0F, 6'h3F);
    applyStimulus("beq",  6'h04, 6'h20);
    applyStimulus("j",    6'h02, 6'h00);
    applyStimulus("badop", 6'h3F, 6'h20);
    applyStimulus("badfn", 6'h00, 6'h27);
    applyStimulus("add",  6'h00, 6'h20);

    // Reset in MEM_RD of lw: mem_read must drop at once, no write-back follows.
    opcode = 6'h23;
    funct  = 6'h00;
    repeat (3) @(posedge clk);
    #1;
    memRd = '0; memRd.mrd = 1; memRd.iord = 1;
    checkOutput("lw_memrd_before_reset", obs, memRd);
    #2;
    applyReset(1);

    for (int k = 0; k < 300; k++) begin
      sel = $urandom_range(0, 9);
      fn  = 6'($urandom);
      if (sel < 8) op = legalOps[$urandom_range(0, 8)];
      else if (sel == 8) op = 6'($urandom);
      else op = 6'h00;
      if (op == 6'h00 && sel != 9) fn = legalFns[$urandom_range(0, 4)];
      applyStimulus($sformatf("rand%0d", k), op, fn);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
